mult_seq_ctrl: RTL
==================

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 Parameters: none; step count fixed at 4 (four 4x4 partial products of an 8x8 multiply).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_a  in  1  reset, asynchronous and active-high.
REQ-004 start  in  1  operation request; rising edge (start=1 while previous-cycle start=0) launches a multiply.
REQ-005 input_sel  out  2  operand-nibble select {a_hi, b_hi} driven to the datapath.
REQ-006 shift_sel  out  2  partial-product shift: 00=0, 01=4, 10=8 bits; 11 unused, never driven.
REQ-007 clk_ena  out  1  accumulator-register load enable.
REQ-008 sclr_n  out  1  accumulator-register synchronous clear, active-low.
REQ-009 done  out  1  result valid in accumulator.
REQ-010 err  out  1  protocol error flag.
REQ-011 state_out  out  3  current state code.
REQ-012 count_out  out  2  current step count.

Function
REQ-013 States and codes: IDLE=0, LSB=1, MID=2, MSB=3, CALC_DONE=4, ERR=5; codes 6-7 SHALL decode as IDLE on the next edge.
REQ-014 start_q register holds previous-cycle start; start_rise = start & ~start_q.
REQ-015 IDLE: clk_ena=0, done=0; sclr_n=~start_rise; on start_rise -> LSB, count=0; else stay.
REQ-016 LSB: input_sel=00, shift_sel=00, clk_ena=1, sclr_n=1; -> MID, count=1.
REQ-017 MID: input_sel=01 when count=1, 10 when count=2; shift_sel=01, clk_ena=1; count=2 -> MSB, count=3; else count increments, stay.
REQ-018 MSB: input_sel=11, shift_sel=10, clk_ena=1; -> CALC_DONE.
REQ-019 CALC_DONE: done=1, clk_ena=0, sclr_n=1; -> IDLE on start=0; held while start=1.
REQ-020 Outputs decode combinationally from state, count and start only; all unlisted outputs 00/0; sclr_n=1 outside IDLE.
REQ-021 Latency: start_rise sampled at edge 1 -> LSB; accumulator loads at edges 2,3,4,5; done=1 from edge 5; done and final product simultaneous.
REQ-022 Count wraps 3->0 only through IDLE; count never exceeds 3.
REQ-023 Start held high through an operation SHALL NOT relaunch; a new multiply requires start low then high.

Reset
REQ-024 reset_a=1 SHALL force state=IDLE, count=0, start_q=0 immediately, independent of clk.
REQ-025 During/after reset with start=0: input_sel=00, shift_sel=00, clk_ena=0, sclr_n=1, done=0, err=0, state_out=0, count_out=0.
REQ-026 Reset mid-operation SHALL abandon the multiply; accumulator contents are undefined until the next start_rise clears it.

Configuration
REQ-027 Macro MULT_SEQ_CTRL_ERR_EN defined: start_rise in LSB, MID or MSB -> ERR; ERR drives err=1, clk_ena=0, done=0; ERR -> IDLE when start=0.
REQ-028 Macro undefined: start_rise in LSB/MID/MSB ignored, sequence completes normally; ERR unreachable; err tied 0; port list unchanged.

Verification
REQ-029 Reset then 1-cycle start pulse -> state_out 0,1,2,2,3,4 on edges 0-5; clk_ena=1 for exactly 4 cycles; done=1 from edge 5.
REQ-030 Datapath bench a=0xFF, b=0xFF, start pulse -> accumulator 0xFE01 when done=1; a=0x12, b=0x34 -> 0x03A8.
REQ-031 start held high 10 cycles -> one multiply only; CALC_DONE held until start=0, then IDLE next edge.
REQ-032 start re-pulsed while state_out=2 -> with MULT_SEQ_CTRL_ERR_EN: state_out=5, err=1, clk_ena=0; without: completes, done=1 at edge 5, err=0.
REQ-033 reset_a asserted mid-clock while state_out=3 -> state_out=0, count_out=0, clk_ena=0 before next edge; subsequent start pulse gives correct product.
REQ-034 Back-to-back: start low one cycle after done, new pulse -> sclr_n=0 in that IDLE cycle, second product correct with no carry-over.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Sequencer for an 8x8 multiply built from four 4x4 partial products.
// Optional feature: define MULT_SEQ_CTRL_ERR_EN to trap a relaunch mid-operation in ERR.
module mult_seq_ctrl (
  input  logic       clk,
  input  logic       reset_a,
  input  logic       start,
  output logic [1:0] input_sel,
  output logic [1:0] shift_sel,
  output logic       clk_ena,
  output logic       sclr_n,
  output logic       done,
  output logic       err,
  output logic [2:0] state_out,
  output logic [1:0] count_out
);

  // Handshake: a rising edge on start launches one multiply; done stays high in
  // CALC_DONE with the product in the accumulator until start is seen low.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LSB       = 3'd1,
    MID       = 3'd2,
    MSB       = 3'd3,
    CALC_DONE = 3'd4,
    ERR       = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] count;
  logic [1:0] count_nxt;
  logic       start_q;
  logic       start_rise;

  assign start_rise = start & ~start_q;
  assign state_out  = state;
  assign count_out  = count;

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state   <= IDLE;
      count   <= 2'd0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      start_q <= start;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    input_sel = 2'b00;
    shift_sel = 2'b00;
    clk_ena   = 1'b0;
    sclr_n    = 1'b1;
    done      = 1'b0;
    err       = 1'b0;

    case (state)
      IDLE: begin
        // Clear the accumulator in the same cycle the launch is accepted.
        sclr_n    = ~start_rise;
        count_nxt = 2'd0;
        if (start_rise) begin
          state_nxt = LSB;
        end
      end
      LSB: begin
        clk_ena   = 1'b1;
        state_nxt = MID;
        count_nxt = 2'd1;
      end
      MID: begin
        input_sel = (count == 2'd1) ? 2'b01 : 2'b10;
        shift_sel = 2'b01;
        clk_ena   = 1'b1;
        if (count >= 2'd2) begin
          state_nxt = MSB;
          count_nxt = 2'd3;
        end else begin
          count_nxt = count + 2'd1;
        end
      end
      MSB: begin
        input_sel = 2'b11;
        shift_sel = 2'b10;
        clk_ena   = 1'b1;
        state_nxt = CALC_DONE;
        count_nxt = 2'd3;
      end
      CALC_DONE: begin
        done = 1'b1;
        if (!start) begin
          state_nxt = IDLE;
          count_nxt = 2'd0;
        end
      end
`ifdef MULT_SEQ_CTRL_ERR_EN
      ERR: begin
        err = 1'b1;
        if (!start) begin
          state_nxt = IDLE;
          count_nxt = 2'd0;
        end
      end
`endif
      default: begin
        // Illegal codes (and ERR when the trap is not built) recover to IDLE.
        state_nxt = IDLE;
        count_nxt = 2'd0;
      end
    endcase

`ifdef MULT_SEQ_CTRL_ERR_EN
    if (start_rise && (state == LSB || state == MID || state == MSB)) begin
      state_nxt = ERR;
    end
`endif
  end

endmodule
